sonic_vc_demux_pkt: RTL

Parametrised N-channel Avalon-ST demultiplexer for the SoNIC virtual-channel path. It carries the bardec/be sideband alongside each beat. Routing is packet-aware: the channel is sampled on the SOP beat and held until EOP. It runs at full throughput (one beat per clock) with registered ready, and drops packets addressed to unmapped channels while counting them. It sits between the PCIe RX stream and the per-VC queues, and is the generalised successor to the fixed 2-channel demux.

---
 rtl/sonic_vc_demux_pkt.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sonic_vc_demux_pkt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sonic_vc_demux_pkt : packet-aware N-channel Avalon-ST demux with 2-entry skid,
// per-channel output registers and drop counting for unmapped channels. Rev 1.0
// ---------------------------------------------------------------------------
module sonic_vc_demux_pkt #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int DATA_W   = 128,
  parameter int EMPTY_W  = 4,
  parameter int BARDEC_W = 8,
  parameter int BE_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CH_W-1:0]              in_channel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_startofpacket,
  input  logic                         in_endofpacket,
  input  logic [EMPTY_W-1:0]           in_empty,
  input  logic [BARDEC_W-1:0]          in_bardec,
  input  logic [BE_W-1:0]              in_be,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*DATA_W-1:0]     out_data,
  output logic [NUM_CH-1:0]            out_startofpacket,
  output logic [NUM_CH-1:0]            out_endofpacket,
  output logic [NUM_CH*EMPTY_W-1:0]    out_empty,
  output logic [NUM_CH*BARDEC_W-1:0]   out_bardec,
  output logic [NUM_CH*BE_W-1:0]       out_be,
  output logic [15:0]                  drop_count,
  output logic                         sop_err
);

  localparam int OW = 2 + EMPTY_W + BARDEC_W + BE_W + DATA_W;
  localparam int PW = CH_W + OW;
  localparam logic [CH_W:0] C_NUM_CH = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CH_W-1:0] lock_ch;

  logic [PW-1:0]   skid_mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      skid_cnt;
  logic [1:0]      cnt_next;
  logic            push;
  logic            pop;

  logic [PW-1:0]   head;
  logic            head_valid;
  logic [CH_W-1:0] head_ch;
  logic            head_sop;
  logic            head_eop;
  logic            head_mapped;
  logic [OW-1:0]   head_pl;

  logic            fwd;
  logic            drop_new;
  logic            err;
  logic [CH_W-1:0] dest;
  logic            dest_free;
  logic [NUM_CH-1:0] stage_free;

  assign head        = skid_mem[rd_ptr];
  assign head_valid  = (skid_cnt != 2'd0);
  assign head_ch     = head[PW-1 -: CH_W];
  assign head_pl     = head[OW-1:0];
  assign head_sop    = head_pl[OW-1];
  assign head_eop    = head_pl[OW-2];
  assign head_mapped = ({1'b0, head_ch} < C_NUM_CH);

  assign push     = in_valid && in_ready;
  assign cnt_next = skid_cnt + 2'(push) - 2'(pop);

  // Skid occupancy; in_ready is registered from the next-cycle occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      skid_cnt <= cnt_next;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      in_ready <= (cnt_next != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      skid_mem[wr_ptr] <= {in_channel, in_startofpacket, in_endofpacket,
                           in_empty, in_bardec, in_be, in_data};
  end

  // A SOP always restarts routing, whatever state the previous packet left.
  always_comb begin
    fwd        = 1'b0;
    drop_new   = 1'b0;
    err        = 1'b0;
    dest       = lock_ch;
    next_state = state;
    if (head_sop) begin
      err = (state != IDLE);
      if (head_mapped) begin
        fwd        = 1'b1;
        dest       = head_ch;
        next_state = head_eop ? IDLE : FWD;
      end else begin
        drop_new   = 1'b1;
        next_state = head_eop ? IDLE : DROP;
      end
    end else begin
      case (state)
        FWD: begin
          fwd = 1'b1;
          if (head_eop) next_state = IDLE;
        end
        DROP: begin
          if (head_eop) next_state = IDLE;
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_comb begin
    dest_free = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (dest == CH_W'(k)) dest_free = stage_free[k];
    end
  end

  assign pop = head_valid && (!fwd || dest_free);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lock_ch    <= '0;
      drop_count <= 16'd0;
      sop_err    <= 1'b0;
    end else begin
      sop_err <= pop && err;
      if (pop) begin
        state <= next_state;
        if (fwd) lock_ch <= dest;
        if (drop_new && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    logic          valid_r;
    logic [OW-1:0] pl_r;
    logic          load;

    assign load          = pop && fwd && (dest == CH_W'(k));
    assign stage_free[k] = out_ready[k] || !valid_r;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)             valid_r <= 1'b0;
      else if (load)         valid_r <= 1'b1;
      else if (out_ready[k]) valid_r <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (load) pl_r <= head_pl;
    end

    assign out_valid[k]                          = valid_r;
    assign out_startofpacket[k]                  = pl_r[OW-1];
    assign out_endofpacket[k]                    = pl_r[OW-2];
    assign out_empty[k*EMPTY_W +: EMPTY_W]       = pl_r[OW-3 -: EMPTY_W];
    assign out_bardec[k*BARDEC_W +: BARDEC_W]    = pl_r[BE_W+DATA_W +: BARDEC_W];
    assign out_be[k*BE_W +: BE_W]                = pl_r[DATA_W +: BE_W];
    assign out_data[k*DATA_W +: DATA_W]          = pl_r[DATA_W-1:0];
  end

endmodule
`default_nettype wire
